// File: rtl/instruction_control_fsm.sv
// instruction_control_fsm: Moore control unit for the single-bus CPU datapath.
// Sequences instruction fetch (T0-T2) and per-opcode execute steps (T3-T7),
// driving every bus source, load enable, ALU op, memory strobe and register
// select. Stop and the halt opcode freeze sequencing at instruction boundaries.
module instruction_control_fsm #(
    parameter int unsigned OPW    = 5,
    parameter logic [4:0]  ADD_OP = 5'b00011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic [7:0]  bus_sel,
    output logic [9:0]  ld_en,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        Clear
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // bus_sel bit positions
    localparam int unsigned BS_PC  = 0;
    localparam int unsigned BS_ZH  = 1;
    localparam int unsigned BS_ZL  = 2;
    localparam int unsigned BS_MDR = 3;
    localparam int unsigned BS_HI  = 4;
    localparam int unsigned BS_LO  = 5;
    localparam int unsigned BS_IN  = 6;
    localparam int unsigned BS_C   = 7;

    // ld_en bit positions
    localparam int unsigned LD_MAR = 0;
    localparam int unsigned LD_PC  = 1;
    localparam int unsigned LD_MDR = 2;
    localparam int unsigned LD_IR  = 3;
    localparam int unsigned LD_Y   = 4;
    localparam int unsigned LD_Z   = 5;
    localparam int unsigned LD_HI  = 6;
    localparam int unsigned LD_LO  = 7;
    localparam int unsigned LD_CON = 8;
    localparam int unsigned LD_OUT = 9;

    // opcodes
    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_BRX  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

    state_t         r_state;
    state_t         w_next;
    logic           r_halt_lock;
    logic           w_set_lock;
    logic           w_done;
    logic [OPW-1:0] w_op;
    logic           w_is_imm;
    logic           w_is_muldiv;
    logic           w_unused_ir;

    assign w_op        = IR[31 -: OPW];
    assign w_unused_ir = ^IR[31-OPW:0];
    assign w_is_imm    = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);

    assign Clear = ~Reset;
    assign Run   = (r_state != S_RST) && (r_state != S_HALT);

    // State register; the halt-opcode lock keeps HALT sticky until reset
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_RST;
            r_halt_lock <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_lock)
                r_halt_lock <= 1'b1;
        end
    end

    // Next-state and Moore control outputs decoded from state and IR opcode
    always_comb begin
        bus_sel    = '0;
        ld_en      = '0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
        alu_op     = '0;
        w_next     = r_state;
        w_done     = 1'b0;
        w_set_lock = 1'b0;

        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                bus_sel[BS_PC] = 1'b1;
                ld_en[LD_MAR]  = 1'b1;
                IncPC          = 1'b1;
                ld_en[LD_Z]    = 1'b1;
                w_next         = S_T1;
            end
            S_T1: begin
                bus_sel[BS_ZL] = 1'b1;
                ld_en[LD_PC]   = 1'b1;
                Read           = 1'b1;
                ld_en[LD_MDR]  = 1'b1;
                w_next         = S_T2;
            end
            S_T2: begin
                bus_sel[BS_MDR] = 1'b1;
                ld_en[LD_IR]    = 1'b1;
                if (w_op == OP_HALT) begin
                    w_next     = S_HALT;
                    w_set_lock = 1'b1;
                end else if (w_op == OP_NOP || w_op > OP_HALT)
                    w_done = 1'b1;
                else
                    w_next = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (r_state)
                    S_T3:    w_next = S_T4;
                    S_T4:    w_next = S_T5;
                    S_T5:    w_next = S_T6;
                    S_T6:    w_next = S_T7;
                    default: w_done = 1'b1;
                endcase
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_MUL, OP_DIV, OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (r_state)
                            S_T3: begin
                                Grb = 1'b1; Rout = 1'b1; ld_en[LD_Y] = 1'b1;
                            end
                            S_T4: begin
                                if (w_is_imm)
                                    bus_sel[BS_C] = 1'b1;
                                else begin
                                    Grc = 1'b1; Rout = 1'b1;
                                end
                                alu_op      = 5'(w_op);
                                ld_en[LD_Z] = 1'b1;
                            end
                            S_T5: begin
                                bus_sel[BS_ZL] = 1'b1;
                                if (w_is_muldiv)
                                    ld_en[LD_LO] = 1'b1;
                                else begin
                                    Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                                end
                            end
                            S_T6: begin
                                bus_sel[BS_ZH] = 1'b1; ld_en[LD_HI] = 1'b1; w_done = 1'b1;
                            end
                            default: w_done = 1'b1;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (r_state)
                            S_T3: begin
                                Grb = 1'b1; Rout = 1'b1; alu_op = 5'(w_op); ld_en[LD_Z] = 1'b1;
                            end
                            S_T4: begin
                                bus_sel[BS_ZL] = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                            end
                            default: w_done = 1'b1;
                        endcase
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        case (r_state)
                            S_T3: begin
                                Grb = 1'b1; BAout = 1'b1; ld_en[LD_Y] = 1'b1;
                            end
                            S_T4: begin
                                bus_sel[BS_C] = 1'b1; alu_op = ADD_OP; ld_en[LD_Z] = 1'b1;
                            end
                            S_T5: begin
                                bus_sel[BS_ZL] = 1'b1;
                                if (w_op == OP_LDI) begin
                                    Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                                end else
                                    ld_en[LD_MAR] = 1'b1;
                            end
                            S_T6: begin
                                ld_en[LD_MDR] = 1'b1;
                                if (w_op == OP_LD)
                                    Read = 1'b1;
                                else begin
                                    Gra = 1'b1; Rout = 1'b1;
                                end
                            end
                            default: begin
                                if (w_op == OP_LD) begin
                                    bus_sel[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                                end else
                                    Write = 1'b1;
                                w_done = 1'b1;
                            end
                        endcase
                    end
                    OP_BRX: begin
                        case (r_state)
                            S_T3: begin
                                Gra = 1'b1; Rout = 1'b1; ld_en[LD_CON] = 1'b1;
                            end
                            S_T4: begin
                                bus_sel[BS_PC] = 1'b1; ld_en[LD_Y] = 1'b1;
                            end
                            S_T5: begin
                                bus_sel[BS_C] = 1'b1; alu_op = ADD_OP; ld_en[LD_Z] = 1'b1;
                            end
                            default: begin
                                bus_sel[BS_ZL] = CON_FF;
                                ld_en[LD_PC]   = CON_FF;
                                w_done         = 1'b1;
                            end
                        endcase
                    end
                    OP_JR: begin
                        Gra = 1'b1; Rout = 1'b1; ld_en[LD_PC] = 1'b1; w_done = 1'b1;
                    end
                    OP_JAL: begin
                        if (r_state == S_T3) begin
                            bus_sel[BS_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1;
                        end else begin
                            Gra = 1'b1; Rout = 1'b1; ld_en[LD_PC] = 1'b1; w_done = 1'b1;
                        end
                    end
                    OP_IN: begin
                        bus_sel[BS_IN] = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                    end
                    OP_OUT: begin
                        Gra = 1'b1; Rout = 1'b1; ld_en[LD_OUT] = 1'b1; w_done = 1'b1;
                    end
                    OP_MFHI: begin
                        bus_sel[BS_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                    end
                    OP_MFLO: begin
                        bus_sel[BS_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; w_done = 1'b1;
                    end
                    default: w_done = 1'b1;
                endcase
            end
            S_HALT: w_next = (r_halt_lock || Stop) ? S_HALT : S_T0;
            default: w_next = S_RST;
        endcase

        // Stop only matters on the edge that leaves an instruction's final step
        if (w_done)
            w_next = Stop ? S_HALT : S_T0;
    end

endmodule

// File: tb/tb_instruction_control_fsm.sv
// Scoreboard bench for instruction_control_fsm: the stimulus process drives
// instructions and pushes the expected per-cycle control vector, built from a
// per-opcode step table; a monitor pops and compares on every falling edge.
module tb_instruction_control_fsm;

    typedef logic [33:0] vec_t;

    // vector layout: {Clear, Run, alu_op, Write, Read, IncPC, BAout, Rout, Rin, Grc, Grb, Gra, ld_en, bus_sel}
    localparam vec_t B_PC  = 34'h1 << 0;
    localparam vec_t B_ZH  = 34'h1 << 1;
    localparam vec_t B_ZL  = 34'h1 << 2;
    localparam vec_t B_MDR = 34'h1 << 3;
    localparam vec_t B_HI  = 34'h1 << 4;
    localparam vec_t B_LO  = 34'h1 << 5;
    localparam vec_t B_IN  = 34'h1 << 6;
    localparam vec_t B_C   = 34'h1 << 7;
    localparam vec_t L_MAR = 34'h1 << 8;
    localparam vec_t L_PC  = 34'h1 << 9;
    localparam vec_t L_MDR = 34'h1 << 10;
    localparam vec_t L_IR  = 34'h1 << 11;
    localparam vec_t L_Y   = 34'h1 << 12;
    localparam vec_t L_Z   = 34'h1 << 13;
    localparam vec_t L_HI  = 34'h1 << 14;
    localparam vec_t L_LO  = 34'h1 << 15;
    localparam vec_t L_CON = 34'h1 << 16;
    localparam vec_t L_OUT = 34'h1 << 17;
    localparam vec_t GRA   = 34'h1 << 18;
    localparam vec_t GRB   = 34'h1 << 19;
    localparam vec_t GRC   = 34'h1 << 20;
    localparam vec_t RIN   = 34'h1 << 21;
    localparam vec_t ROUT  = 34'h1 << 22;
    localparam vec_t BAOUT = 34'h1 << 23;
    localparam vec_t INC   = 34'h1 << 24;
    localparam vec_t RD    = 34'h1 << 25;
    localparam vec_t WR    = 34'h1 << 26;
    localparam vec_t RUN   = 34'h1 << 32;
    localparam vec_t CLR   = 34'h1 << 33;

    logic        Clock;
    logic        Reset;
    logic        Stop;
    logic [31:0] IR;
    logic        CON_FF;
    logic [7:0]  bus_sel;
    logic [9:0]  ld_en;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        Run;
    logic        Clear;

    instruction_control_fsm #(.OPW(5), .ADD_OP(5'b00011)) dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON_FF(CON_FF),
        .bus_sel(bus_sel), .ld_en(ld_en),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .alu_op(alu_op), .Run(Run), .Clear(Clear)
    );

    vec_t act;
    assign act = {Clear, Run, alu_op, Write, Read, IncPC, BAout, Rout, Rin, Grc, Grb, Gra, ld_en, bus_sel};

    vec_t  exp_q[$];
    string name_q[$];
    vec_t  steps[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    function automatic vec_t alu(input logic [4:0] op);
        return vec_t'(op) << 27;
    endfunction

    task automatic push_step(input vec_t v);
        steps.push_back(RUN | v);
    endtask

    // Expected cycle-by-cycle control vectors for one instruction, T0 onwards
    task automatic build(input logic [4:0] op, input logic con);
        steps.delete();
        push_step(B_PC | L_MAR | INC | L_Z);
        push_step(B_ZL | L_PC | RD | L_MDR);
        push_step(B_MDR | L_IR);
        case (op) inside
            [5'd3:5'd10]: begin
                push_step(GRB | ROUT | L_Y);
                push_step(GRC | ROUT | alu(op) | L_Z);
                push_step(B_ZL | GRA | RIN);
            end
            5'd14, 5'd15: begin
                push_step(GRB | ROUT | L_Y);
                push_step(GRC | ROUT | alu(op) | L_Z);
                push_step(B_ZL | L_LO);
                push_step(B_ZH | L_HI);
            end
            [5'd11:5'd13]: begin
                push_step(GRB | ROUT | L_Y);
                push_step(B_C | alu(op) | L_Z);
                push_step(B_ZL | GRA | RIN);
            end
            5'd16, 5'd17: begin
                push_step(GRB | ROUT | alu(op) | L_Z);
                push_step(B_ZL | GRA | RIN);
            end
            5'd1: begin
                push_step(GRB | BAOUT | L_Y);
                push_step(B_C | alu(5'd3) | L_Z);
                push_step(B_ZL | GRA | RIN);
            end
            5'd0: begin
                push_step(GRB | BAOUT | L_Y);
                push_step(B_C | alu(5'd3) | L_Z);
                push_step(B_ZL | L_MAR);
                push_step(RD | L_MDR);
                push_step(B_MDR | GRA | RIN);
            end
            5'd2: begin
                push_step(GRB | BAOUT | L_Y);
                push_step(B_C | alu(5'd3) | L_Z);
                push_step(B_ZL | L_MAR);
                push_step(GRA | ROUT | L_MDR);
                push_step(WR);
            end
            5'd18: begin
                push_step(GRA | ROUT | L_CON);
                push_step(B_PC | L_Y);
                push_step(B_C | alu(5'd3) | L_Z);
                push_step(con ? (B_ZL | L_PC) : '0);
            end
            5'd19: push_step(GRA | ROUT | L_PC);
            5'd20: begin
                push_step(B_PC | GRB | RIN);
                push_step(GRA | ROUT | L_PC);
            end
            5'd21: push_step(B_IN | GRA | RIN);
            5'd22: push_step(GRA | ROUT | L_OUT);
            5'd23: push_step(B_HI | GRA | RIN);
            5'd24: push_step(B_LO | GRA | RIN);
            default: ;
        endcase
    endtask

    task automatic expect_cycle(input vec_t v, input string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    task automatic reset_seq();
        cyc(); Reset = 1'b0; Stop = 1'($urandom); expect_cycle(CLR, "reset");
        cyc(); Stop = 1'($urandom); expect_cycle(CLR, "reset");
        cyc(); Reset = 1'b1; Stop = 1'b0; expect_cycle('0, "reset_release");
    endtask

    // One instruction; stop_from forces Stop high on mid steps from that index,
    // stop_end is Stop on the final step, halt_cycles extra Stop-held HALT cycles
    task automatic run_instr(input logic [4:0] op, input logic con, input logic stop_end,
                             input int stop_from, input logic rand_mid, input int halt_cycles);
        logic [31:0] ir;
        build(op, con);
        ir = {op, 27'($urandom)};
        for (int i = 0; i < steps.size(); i++) begin
            cyc();
            IR     = ir;
            CON_FF = con;
            if (i == steps.size() - 1)
                Stop = stop_end;
            else if (i >= stop_from)
                Stop = 1'b1;
            else
                Stop = rand_mid ? 1'($urandom) : 1'b0;
            expect_cycle(steps[i], $sformatf("op%0d_T%0d", op, i));
        end
        if (stop_end) begin
            for (int h = 0; h < halt_cycles; h++) begin
                cyc(); Stop = 1'b1; expect_cycle('0, "stop_halt");
            end
            cyc(); Stop = 1'b0; expect_cycle('0, "stop_halt_exit");
        end
    endtask

    task automatic abort_instr(input logic [4:0] op, input int k);
        logic [31:0] ir;
        build(op, 1'($urandom));
        ir = {op, 27'($urandom)};
        for (int i = 0; i < k; i++) begin
            cyc();
            IR   = ir;
            Stop = 1'($urandom);
            expect_cycle(steps[i], $sformatf("abort_op%0d_T%0d", op, i));
        end
        reset_seq();
    endtask

    task automatic halt_op_test();
        build(5'd26, 1'b0);
        for (int i = 0; i < steps.size(); i++) begin
            cyc();
            IR   = {5'd26, 27'($urandom)};
            Stop = 1'b0;
            expect_cycle(steps[i], $sformatf("halt_T%0d", i));
        end
        for (int h = 0; h < 6; h++) begin
            cyc();
            Stop = h[0];
            expect_cycle('0, "halt_locked");
        end
        reset_seq();
    endtask

    // Monitor: compare every presented output vector against the scoreboard head
    initial begin
        vec_t  e;
        string nm;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", nm, act, e);
                end
            end
        end
    end

    initial begin
        logic [4:0] op;
        Reset  = 1'b0;
        Stop   = 1'b0;
        IR     = '0;
        CON_FF = 1'b0;

        reset_seq();
        run_instr(5'd3,  1'b0, 1'b0, 99, 1'b0, 0);   // add
        run_instr(5'd2,  1'b0, 1'b0, 99, 1'b0, 0);   // st
        run_instr(5'd18, 1'b0, 1'b0, 99, 1'b0, 0);   // brx not taken
        run_instr(5'd18, 1'b1, 1'b0, 99, 1'b0, 0);   // brx taken
        run_instr(5'd3,  1'b0, 1'b1, 4,  1'b0, 2);   // Stop raised in T4
        run_instr(5'd25, 1'b0, 1'b0, 99, 1'b1, 0);   // nop
        run_instr(5'd28, 1'b0, 1'b1, 99, 1'b1, 1);   // undefined, stop at T2
        run_instr(5'd0,  1'b0, 1'b0, 99, 1'b1, 0);   // ld
        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26)
                op = 5'd14;
            if ($urandom_range(0, 9) == 0) begin
                build(op, 1'b0);
                abort_instr(op, $urandom_range(1, steps.size() - 1));
            end else
                run_instr(op, 1'($urandom), ($urandom_range(0, 3) == 0), 99, 1'b1,
                          $urandom_range(0, 2));
        end
        halt_op_test();
        run_instr(5'd3, 1'b0, 1'b0, 99, 1'b0, 0);

        repeat (3) @(negedge Clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
